registers: RTL and testbench
============================

Name: registers

Overview:
- Register file of the CPU datapath: 8 general registers, each 20 bits (R0=AX, R1=BX, R2=CX, R3=DX, R4..R7 general).
- Provides one synchronous write port and one registered read port.
- Full-word mode accesses a whole register.
- Half-word mode accesses a 10-bit low/high half of AX..DX (AXL, AXH, ... DXH), as used by byte-style instructions.

Parameters:
- DATA_W, 20, register width in bits; half width = DATA_W/2 (10). Must be even.
- ADDR_W, 3, select width; number of registers = 2**ADDR_W (8).

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-low reset (low = reset).
- readsig  input  1  read enable; when high, data_read is updated on the clock edge.
- writesig  input  1  write enable; when high, the selected register/half is written on the clock edge.
- sr  input  ADDR_W  source select for reads.
- dr  input  ADDR_W  destination select for writes.
- halfword  input  1  0 = full-word access, 1 = half-word access; applies to both read and write in that cycle.
- data_write  input  DATA_W  write data; only bits [9:0] are used in half-word mode.
- data_read  output  DATA_W  registered read data.

Behaviour:
- Reset: on a rising clk edge with reset=0, all 8 registers and data_read clear to 0. Reset has priority over read and write in that cycle.
- Write, full-word (halfword=0): on the edge with writesig=1, R[dr] <= data_write.
- Write, half-word (halfword=1): select s = dr.
  - Target register = R[s[2:1]] (AX..DX only); s[0]=0 selects bits [9:0] (xL), s[0]=1 selects bits [19:10] (xH).
  - The selected half <= data_write[9:0]; the other half and all other registers are unchanged.
- Read, full-word: on the edge with readsig=1, data_read <= R[sr].
- Read, half-word: same mapping using sr. data_read <= {10'b0, selected half}, zero-extended.
- Read latency: 1 clock; data_read holds its last value while readsig=0.
- Simultaneous read and write: both occur in the same edge. A read of the register being written returns the pre-write (old) value; the new value is visible on the next read.
- Writes with writesig=0 never modify state. X/undriven sr is irrelevant when readsig=0.
- No other outputs, flags or exceptions. Register contents persist indefinitely without reset.

Test Plan:
- Reset: hold reset=0 one edge, then readsig=1, sr=0..7 -> data_read=0x00000 each cycle.
- Full-word write/read: halfword=0, writesig=1, dr=0, data_write=0x00055; next cycle writesig=0, readsig=1, sr=0 -> data_read=0x00055 one edge later.
- Half-word low write: after reset, halfword=1, dr=0 (AXL), data_write=0x00001; then read sr=0 half -> 0x00001; full read sr=0 -> 0x00001. Write dr=1 (AXH) 0x3FF -> full read of AX = 0xFFC01, half read sr=1 = 0x003FF.
- Half-write preserves other half: full write BX=0xABCDE; half write dr=2 (BXL) 0x000 -> full read BX = 0xABC00.
- Read-during-write: R3=0x12345; same edge writesig=1, dr=3, data_write=0x54321, readsig=1, sr=3 -> data_read=0x12345; next read -> 0x54321.
- Mid-operation reset: writesig=1, dr=5, data_write=0xFFFFF with reset=0 in the same edge -> R5 stays 0 and data_read=0.

Source files
------------

// File: rtl/registers.sv
// Datapath register file: eight DATA_W-bit registers with one synchronous
// write port and one registered read port. Half-word mode reaches the low
// and high halves of R0..R3 (AX..DX) through the 3-bit select: bits [2:1]
// pick the register and bit 0 picks the half (0 = low, 1 = high).
//
// Handshake: there is no flow control. A high readsig or writesig is a
// single-cycle command that is always accepted on the next rising clk edge.
// data_read is valid one edge after readsig and holds while readsig is low.
module registers #(
   parameter int DATA_W = 20,   // must be even
   parameter int ADDR_W = 3
) (
   input  logic              clk,
   input  logic              reset,        // synchronous, active low
   input  logic              readsig,
   input  logic              writesig,
   input  logic [ADDR_W-1:0] sr,
   input  logic [ADDR_W-1:0] dr,
   input  logic              halfword,
   input  logic [DATA_W-1:0] data_write,
   output logic [DATA_W-1:0] data_read
);

   localparam int HALF_W   = DATA_W / 2;
   localparam int NUM_REGS = 2 ** ADDR_W;

   logic [DATA_W-1:0] regs_q [NUM_REGS];
   logic [DATA_W-1:0] regs_d [NUM_REGS];
   logic [DATA_W-1:0] data_read_q;
   logic [DATA_W-1:0] data_read_d;

   // Half-word selects map onto the lower registers only (select >> 1).
   logic [ADDR_W-1:0] wr_half_idx;
   logic [ADDR_W-1:0] rd_half_idx;

   assign wr_half_idx = {1'b0, dr[ADDR_W-1:1]};
   assign rd_half_idx = {1'b0, sr[ADDR_W-1:1]};

   // Next register contents: full-word or single-half update of the target.
   always_comb begin
      for (int i = 0; i < NUM_REGS; i++) begin
         regs_d[i] = regs_q[i];
      end
      if (writesig) begin
         if (!halfword) begin
            regs_d[dr] = data_write;
         end else if (dr[0]) begin
            regs_d[wr_half_idx][DATA_W-1:HALF_W] = data_write[HALF_W-1:0];
         end else begin
            regs_d[wr_half_idx][HALF_W-1:0] = data_write[HALF_W-1:0];
         end
      end
   end

   // Next read data comes from the current (pre-write) contents, so a read of
   // a register written on the same edge returns its old value.
   always_comb begin
      data_read_d = data_read_q;
      if (readsig) begin
         if (!halfword) begin
            data_read_d = regs_q[sr];
         end else if (sr[0]) begin
            data_read_d = {{(DATA_W-HALF_W){1'b0}}, regs_q[rd_half_idx][DATA_W-1:HALF_W]};
         end else begin
            data_read_d = {{(DATA_W-HALF_W){1'b0}}, regs_q[rd_half_idx][HALF_W-1:0]};
         end
      end
   end

   // State update; reset wins over any read or write in the same cycle.
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= '0;
         end
         data_read_q <= '0;
      end else begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= regs_d[i];
         end
         data_read_q <= data_read_d;
      end
   end

   assign data_read = data_read_q;

endmodule

// File: tb/tb_registers.sv
// Bench for the register file: directed scenarios with literal expectations
// plus randomized traffic checked against an arithmetic model of the file.
module tb_registers;

   localparam int W = 20;

   logic         clk;
   logic         reset;
   logic         readsig;
   logic         writesig;
   logic [2:0]   sr;
   logic [2:0]   dr;
   logic         halfword;
   logic [W-1:0] data_write;
   logic [W-1:0] data_read;

   int total = 0;
   int bad   = 0;

   // Reference model: plain array of register values plus last read result.
   logic [W-1:0] mdl [8];
   logic [W-1:0] exp_rd;
   logic [W-1:0] exp_q [$];

   registers #(.DATA_W(20), .ADDR_W(3)) dut (
      .clk        (clk),
      .reset      (reset),
      .readsig    (readsig),
      .writesig   (writesig),
      .sr         (sr),
      .dr         (dr),
      .halfword   (halfword),
      .data_write (data_write),
      .data_read  (data_read)
   );

   // Clock generation
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [W-1:0] model_read(input logic [2:0] s, input logic hw);
      int unsigned v;
      int unsigned idx;
      if (!hw) return mdl[s];
      idx = int'(s) / 2;
      v = int'(mdl[idx]);
      v = (v >> (10 * (int'(s) % 2))) % 1024;
      return W'(v);
   endfunction

   function automatic void model_write(input logic [2:0] d, input logic hw,
                                       input logic [W-1:0] wd);
      int unsigned v;
      int unsigned idx;
      int unsigned lo;
      int unsigned hi;
      int unsigned nw;
      if (!hw) begin
         mdl[d] = wd;
      end else begin
         idx = int'(d) / 2;
         v   = int'(mdl[idx]);
         lo  = v % 1024;
         hi  = v / 1024;
         nw  = int'(wd) % 1024;
         if (int'(d) % 2 == 1) hi = nw;
         else                  lo = nw;
         mdl[idx] = W'(hi * 1024 + lo);
      end
   endfunction

   // Drive one clock cycle of stimulus and advance the model alongside it.
   task automatic cyc(input logic rst_n, input logic rd, input logic wr,
                      input logic hw, input logic [2:0] s, input logic [2:0] d,
                      input logic [W-1:0] wd);
      reset      = rst_n;
      readsig    = rd;
      writesig   = wr;
      halfword   = hw;
      sr         = s;
      dr         = d;
      data_write = wd;
      if (!rst_n) begin
         for (int i = 0; i < 8; i++) mdl[i] = '0;
         exp_rd = '0;
      end else begin
         if (rd) exp_rd = model_read(s, hw);
         if (wr) model_write(d, hw, wd);
      end
      @(posedge clk);
      #1;
      readsig  = 1'b0;
      writesig = 1'b0;
   endtask

   task automatic test_reset();
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, '0);
      total++;
      if (data_read !== 20'h00000) begin
         bad++;
         $display("FAIL reset_out: got %h expected %h", data_read, 20'h00000);
      end
      for (int i = 0; i < 8; i++) begin
         cyc(1'b1, 1'b1, 1'b0, 1'b0, 3'(i), 3'd0, '0);
         total++;
         if (data_read !== 20'h00000) begin
            bad++;
            $display("FAIL reset_reg%0d: got %h expected %h", i, data_read, 20'h00000);
         end
      end
   endtask

   task automatic test_full_word();
      cyc(1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 3'd0, 20'h00055);
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 3'd0, '0);
      total++;
      if (data_read !== 20'h00055) begin
         bad++;
         $display("FAIL full_word: got %h expected %h", data_read, 20'h00055);
      end
      // Read enable low: output must hold.
      cyc(1'b1, 1'b0, 1'b1, 1'b0, 3'd7, 3'd0, 20'h11111);
      total++;
      if (data_read !== 20'h00055) begin
         bad++;
         $display("FAIL hold: got %h expected %h", data_read, 20'h00055);
      end
   endtask

   task automatic test_half_low_high();
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, '0);
      cyc(1'b1, 1'b0, 1'b1, 1'b1, 3'd0, 3'd0, 20'h00001);
      cyc(1'b1, 1'b1, 1'b0, 1'b1, 3'd0, 3'd0, '0);
      total++;
      if (data_read !== 20'h00001) begin
         bad++;
         $display("FAIL axl_half: got %h expected %h", data_read, 20'h00001);
      end
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 3'd0, '0);
      total++;
      if (data_read !== 20'h00001) begin
         bad++;
         $display("FAIL axl_full: got %h expected %h", data_read, 20'h00001);
      end
      cyc(1'b1, 1'b0, 1'b1, 1'b1, 3'd0, 3'd1, 20'h003FF);
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 3'd0, '0);
      total++;
      if (data_read !== 20'hFFC01) begin
         bad++;
         $display("FAIL axh_full: got %h expected %h", data_read, 20'hFFC01);
      end
      cyc(1'b1, 1'b1, 1'b0, 1'b1, 3'd1, 3'd0, '0);
      total++;
      if (data_read !== 20'h003FF) begin
         bad++;
         $display("FAIL axh_half: got %h expected %h", data_read, 20'h003FF);
      end
   endtask

   task automatic test_half_preserve();
      cyc(1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 3'd1, 20'hABCDE);
      cyc(1'b1, 1'b0, 1'b1, 1'b1, 3'd0, 3'd2, 20'h00000);
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 3'd1, 3'd0, '0);
      total++;
      if (data_read !== 20'hABC00) begin
         bad++;
         $display("FAIL bxl_preserve: got %h expected %h", data_read, 20'hABC00);
      end
      cyc(1'b1, 1'b1, 1'b0, 1'b1, 3'd3, 3'd0, '0);
      total++;
      if (data_read !== 20'h002AF) begin
         bad++;
         $display("FAIL bxh_half: got %h expected %h", data_read, 20'h002AF);
      end
   endtask

   task automatic test_read_during_write();
      cyc(1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 3'd3, 20'h12345);
      cyc(1'b1, 1'b1, 1'b1, 1'b0, 3'd3, 3'd3, 20'h54321);
      total++;
      if (data_read !== 20'h12345) begin
         bad++;
         $display("FAIL rdw_old: got %h expected %h", data_read, 20'h12345);
      end
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 3'd3, 3'd0, '0);
      total++;
      if (data_read !== 20'h54321) begin
         bad++;
         $display("FAIL rdw_new: got %h expected %h", data_read, 20'h54321);
      end
   endtask

   task automatic test_mid_reset();
      // data_read is non-zero (0x54321) going into the reset edge.
      cyc(1'b0, 1'b1, 1'b1, 1'b0, 3'd3, 3'd5, 20'hFFFFF);
      total++;
      if (data_read !== 20'h00000) begin
         bad++;
         $display("FAIL midrst_out: got %h expected %h", data_read, 20'h00000);
      end
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 3'd5, 3'd0, '0);
      total++;
      if (data_read !== 20'h00000) begin
         bad++;
         $display("FAIL midrst_r5: got %h expected %h", data_read, 20'h00000);
      end
   endtask

   task automatic test_random();
      logic         rd, wr, hw;
      logic [2:0]   s, d;
      logic [W-1:0] wd;
      logic [W-1:0] e;
      for (int n = 0; n < 300; n++) begin
         rd = 1'($urandom_range(0, 1));
         wr = 1'($urandom_range(0, 1));
         hw = 1'($urandom_range(0, 1));
         s  = 3'($urandom_range(0, 7));
         d  = 3'($urandom_range(0, 7));
         wd = 20'($urandom);
         cyc(1'b1, rd, wr, hw, s, d, wd);
         exp_q.push_back(exp_rd);
         e = exp_q.pop_front();
         total++;
         if (data_read !== e) begin
            bad++;
            $display("FAIL random_%0d: got %h expected %h", n, data_read, e);
         end
      end
      // Sweep every register in full-word mode to compare whole contents.
      for (int i = 0; i < 8; i++) begin
         cyc(1'b1, 1'b1, 1'b0, 1'b0, 3'(i), 3'd0, '0);
         total++;
         if (data_read !== mdl[i]) begin
            bad++;
            $display("FAIL sweep_r%0d: got %h expected %h", i, data_read, mdl[i]);
         end
      end
   endtask

   initial begin
      reset      = 1'b0;
      readsig    = 1'b0;
      writesig   = 1'b0;
      halfword   = 1'b0;
      sr         = '0;
      dr         = '0;
      data_write = '0;
      exp_rd     = '0;
      for (int i = 0; i < 8; i++) mdl[i] = '0;
      @(posedge clk);
      #1;
      test_reset();
      test_full_word();
      test_half_low_high();
      test_half_preserve();
      test_read_during_write();
      test_mid_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
